// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// memory-wait stall with sticky timeout and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TMO   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       dRs,
  input  logic [3:0]       dRt,
  input  logic             dRsUsed,
  input  logic             dRtUsed,
  input  logic             dNOP,
  input  logic [3:0]       eRd,
  input  logic             eRdEnable,
  input  logic             eLdEnable,
  input  logic             eNOP,
  input  logic             eBranchTaken,
  input  logic [3:0]       mRd,
  input  logic             mRdEnable,
  input  logic             memBusy,
  output logic             Stall,
  output logic             Flush,
  output logic [1:0]       fwdRs,
  output logic [1:0]       fwdRt,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCnt,
  output logic [1:0]       state
);

  localparam int unsigned      WaitW  = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam logic [WaitW-1:0] TmoVal = WaitW'(TMO);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StFlush   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_live, rt_live, rs_ex, rt_ex, rs_mem, rt_mem;
  logic ex_fwd_ok, lu, br;

  // A "live" operand is a real read of a nonzero register; r0 never hazards.
  assign rs_live   = dRsUsed & ~dNOP & (dRs != 4'd0);
  assign rt_live   = dRtUsed & ~dNOP & (dRt != 4'd0);
  assign rs_ex     = rs_live & (eRd == dRs);
  assign rt_ex     = rt_live & (eRd == dRt);
  assign rs_mem    = rs_live & mRdEnable & (mRd == dRs);
  assign rt_mem    = rt_live & mRdEnable & (mRd == dRt);
  assign ex_fwd_ok = ~eNOP & eRdEnable & ~eLdEnable;
  assign lu        = ~eNOP & eLdEnable & eRdEnable & (rs_ex | rt_ex);
  assign br        = eBranchTaken & ~eNOP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = StRun;
    unique case (state_q)
      StRun: begin
        if (memBusy)  state_d = StMemWait;
        else if (br)  state_d = StFlush;
        else          state_d = StRun;
      end
      StMemWait: state_d = memBusy ? StMemWait : StRun;
      // A branch seen here is a flushed bubble, so it is ignored.
      StFlush:   state_d = memBusy ? StMemWait : StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    Flush = 1'b0;
    fwdRs = 2'b00;
    fwdRt = 2'b00;
    unique case (state_q)
      StRun: begin
        Stall = memBusy | (lu & ~br);
        Flush = ~memBusy & br;
      end
      StMemWait: Stall = memBusy | (lu & ~br);
      StFlush: begin
        Stall = memBusy;
        Flush = 1'b1;
      end
      default: ;
    endcase
    if (rs_ex & ex_fwd_ok)  fwdRs = 2'b01;
    else if (rs_mem)        fwdRs = 2'b10;
    if (rt_ex & ex_fwd_ok)  fwdRt = 2'b01;
    else if (rt_mem)        fwdRt = 2'b10;
    if (rst) begin
      Stall = 1'b0;
      Flush = 1'b0;
      fwdRs = 2'b00;
      fwdRt = 2'b00;
    end
  end

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (state_q == StMemWait && memBusy) begin
      wait_d = (wait_q == TmoVal) ? wait_q : wait_q + WaitW'(1);
      if (wait_d == TmoVal) timeout_d = 1'b1;
    end
    cnt_d = (Stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign memTimeout = timeout_q;
  assign stallCnt   = cnt_q;
  assign state      = state_q;

endmodule
